adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares the processor's single 32-bit carry-lookahead adder among up to four requesters (ALU, address generation, PC increment, branch target). Arbitration is round-robin with a valid/ready handshake per requester. One registered, stallable response port carries the sum, flags and requester ID. The block sits between the issue logic and the adder datapath and is the only driver of the adder's operands.

## Interface
- NREQ, 4: number of requesters; fixed at 4 in this revision, ID width 2.
- WIDTH, 32: operand and result width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero; combinational.
- req_a  in  NREQ*WIDTH  left operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  right operands, same packing.
- req_sub  in  NREQ  1 = compute a - b, 0 = compute a + b.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  2  index of the requester that owns the result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry out of the MSB; for subtraction this is the not-borrow.
- rsp_ovf  out  1  two's-complement signed overflow.

## Operation
- FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Transitions:
  - EMPTY→FULL on any grant.
  - FULL→EMPTY when rsp_ready=1 and no grant.
  - FULL→FULL when rsp_ready=1 with a new grant, or when rsp_ready=0.
- Grant enable: state EMPTY, or state FULL with rsp_ready=1 (drain and refill in the same cycle).
- Arbitration:
  - Search req_valid starting at pointer ptr, wrapping modulo NREQ; the first set bit wins.
  - req_ready is asserted only for the winner and only while grant is enabled.
  - After a grant to requester g, ptr ← (g+1) mod NREQ. ptr is unchanged when there is no grant.
- A transfer occurs when req_valid[i] & req_ready[i]. A requester holds valid and its operands stable until it sees ready.
- Arithmetic: {cout,sum} = a + (sub ? ~b : b) + sub, computed at WIDTH+1 bits.
  - ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' is the inverted b when subtracting.
- The response registers load only on a transfer. While FULL and rsp_ready=0, all rsp_* outputs hold stable.
- req_ready never depends on rsp_valid combinationally beyond the grant-enable term. There is no path from req_valid to rsp_*.

## Timing
- Reset (asynchronous assert, synchronous release):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, ptr=0, state EMPTY.
  - req_ready=0 while rst_n=0.
- Latency: a transfer at edge N gives rsp_valid=1 with the result after edge N, i.e. one cycle.
- Throughput: one result per cycle while rsp_ready stays high.
- Backpressure: rsp_ready=0 while FULL drives all req_ready to 0 in that cycle.
- Simultaneous drain and grant: old result consumed and new result loaded on the same edge; rsp_valid stays 1 with no bubble.
- Fairness: a continuously asserted request is granted within NREQ grants.
- Reset mid-operation: any held result is discarded and ptr returns to 0. Requesters reissue.
- Wrap-around: ptr at 3, granted 3, goes to 0.
- Operands: a sum of 0xFFFFFFFF + 1 wraps to 0 with cout=1.

## Test plan
- Reset, then req_valid=4'b0001, a=5, b=7, sub=0, rsp_ready=1: req_ready=0001 in the same cycle; next cycle rsp_valid=1, id=0, sum=12, cout=0, ovf=0.
- All four requesting continuously, rsp_ready=1: grants in order 0,1,2,3,0,…; one result per cycle with matching rsp_id.
- Arithmetic corners:
  - 0x7FFFFFFF + 1 → sum 0x80000000, ovf=1, cout=0.
  - 0xFFFFFFFF + 1 → sum 0, cout=1, ovf=0.
  - 3 − 5 (sub=1) → 0xFFFFFFFE, cout=0.
  - 5 − 3 → 2, cout=1.
- Backpressure: result held, then rsp_ready=0 for 3 cycles with requester 2 valid → req_ready=0 and rsp_* stable. On rsp_ready=1, requester 2 is granted the same cycle and its result appears on the next cycle with no bubble.
- Assert rst_n=0 mid-cycle while FULL with ptr=2 → rsp_valid drops immediately without waiting for a clock edge. After release, requesters 0 and 3 both valid → 0 granted first.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Requester/consumer side of the shared adder: per-requester valid/ready with packed operands,
// plus one registered, stallable response port.
interface adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract datapath among NREQ requesters,
// with a single registered response slot that can drain and refill on the same edge.
//
// state | meaning
// EMPTY | response slot free, rsp_valid=0
// FULL  | response slot holds a result, rsp_valid=1
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  adder_arbiter_if.slave bus
);
  localparam int IDW = 2;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic             grant_en;
  logic             found;
  logic             xfer;
  logic [IDW-1:0]   gid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_b_eff;
  logic             op_sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic             rsp_ovf_q;

  // Pointer arithmetic wraps naturally because NREQ is a power of two (4).
  always_comb begin
    found = 1'b0;
    gid   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[ptr + IDW'(k)]) begin
        found = 1'b1;
        gid   = ptr + IDW'(k);
      end
    end
  end

  assign grant_en      = rst_n & ((state == EMPTY) | bus.rsp_ready);
  assign xfer          = grant_en & found;
  assign bus.req_ready = xfer ? (NREQ'(1) << gid) : '0;

  always_comb begin
    op_a     = bus.req_a[int'(gid)*WIDTH +: WIDTH];
    op_b     = bus.req_b[int'(gid)*WIDTH +: WIDTH];
    op_sub   = bus.req_sub[gid];
    op_b_eff = op_sub ? ~op_b : op_b;
    {cout, sum} = {1'b0, op_a} + {1'b0, op_b_eff} + {{WIDTH{1'b0}}, op_sub};
    ovf = (op_a[WIDTH-1] == op_b_eff[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else if (xfer) begin
      state      <= FULL;
      ptr        <= gid + IDW'(1);
      rsp_id_q   <= gid;
      rsp_sum_q  <= sum;
      rsp_cout_q <= cout;
      rsp_ovf_q  <= ovf;
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized check of adder_arbiter against a queue-free behavioural model
// (round-robin search over integer indices, arithmetic in 64-bit integers).
module tb_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  bit          cv [NREQ];
  logic [31:0] ca [NREQ];
  logic [31:0] cb [NREQ];
  bit          cs [NREQ];
  int          wait_cnt [NREQ];
  int          mode;

  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_sum;
  bit          m_cout;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = cv[i];
      bus.req_a[i*WIDTH +: WIDTH]  = ca[i];
      bus.req_b[i*WIDTH +: WIDTH]  = cb[i];
      bus.req_sub[i]               = cs[i];
    end
  endtask

  task automatic reset_model();
    m_ptr = 0; m_valid = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
  endtask

  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] sum, output bit cout, output bit ovf);
    longint sa, sb, r;
    longint unsigned ua, ub;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    if (s) begin
      sum  = a - b;
      cout = (ua >= ub);
      r    = sa - sb;
    end else begin
      sum  = a + b;
      cout = ((ua + ub) >> 32) != 0;
      r    = sa + sb;
    end
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic new_req(input int i);
    cv[i] = 1; ca[i] = rand_op(); cb[i] = rand_op(); cs[i] = 1'($urandom_range(0, 1));
    wait_cnt[i] = 0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input bit s);
    cv[i] = 1; ca[i] = a; cb[i] = b; cs[i] = s; wait_cnt[i] = 0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) cv[i] = 0;
  endtask

  // One clock: enter at a negedge, check grants before the edge, outputs after it.
  task automatic cycle(input bit rdy);
    int w;
    bit en;
    logic [3:0] exp_rdy;
    logic [31:0] s;
    bit co, ov;
    bus.rsp_ready = rdy;
    drive();
    #1;
    en = !m_valid || rdy;
    w  = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && cv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    if (!en) w = -1;
    exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (w >= 0) begin
      ref_add(ca[w], cb[w], cs[w], s, co, ov);
      m_valid = 1; m_id = w; m_sum = s; m_cout = co; m_ovf = ov;
      m_ptr = (w + 1) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i != w && cv[i]) begin
          wait_cnt[i]++;
          chk("fairness", 64'(wait_cnt[i] < NREQ), 64'd1);
        end
      end
      wait_cnt[w] = 0;
      if (mode == 0) cv[w] = 0;
      else if (mode == 2) begin
        if ($urandom_range(0, 1) == 1) new_req(w);
        else cv[w] = 0;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (mode == 2)
      for (int i = 0; i < NREQ; i++)
        if (!cv[i] && $urandom_range(0, 2) == 0) new_req(i);
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("rsp_id",    64'(bus.rsp_id),    64'(m_id));
    chk("rsp_sum",   64'(bus.rsp_sum),   64'(m_sum));
    chk("rsp_cout",  64'(bus.rsp_cout),  64'(m_cout));
    chk("rsp_ovf",   64'(bus.rsp_ovf),   64'(m_ovf));
    @(negedge clk);
  endtask

  task automatic corner(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [31:0] esum, input bit ecout, input bit eovf);
    set_req(1, a, b, s);
    cycle(1'b1);
    chk("corner_sum",  64'(bus.rsp_sum),  64'(esum));
    chk("corner_cout", 64'(bus.rsp_cout), 64'(ecout));
    chk("corner_ovf",  64'(bus.rsp_ovf),  64'(eovf));
  endtask

  initial begin
    mode = 0;
    for (int i = 0; i < NREQ; i++) begin
      cv[i] = 0; ca[i] = '0; cb[i] = '0; cs[i] = 0;
    end
    bus.rsp_ready = 1'b0;
    drive();
    reset_model();

    // Reset state, with all requests raised while held in reset.
    #2;
    for (int i = 0; i < NREQ; i++) cv[i] = 1;
    drive();
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    clear_reqs();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request 5 + 7.
    set_req(0, 32'd5, 32'd7, 1'b0);
    cycle(1'b1);
    chk("t1_id",  64'(bus.rsp_id),  64'd0);
    chk("t1_sum", 64'(bus.rsp_sum), 64'd12);

    // All four requesting continuously.
    mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    repeat (9) cycle(1'b1);
    mode = 0;
    clear_reqs();
    cycle(1'b1);

    // Arithmetic corners.
    corner(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    corner(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    corner(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    corner(32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0);

    // Backpressure with requester 2 waiting, then drain-and-refill.
    set_req(0, 32'd1, 32'd2, 1'b0);
    cycle(1'b1);
    set_req(2, 32'd10, 32'd20, 1'b0);
    repeat (3) begin
      cycle(1'b0);
      chk("bp_hold_sum", 64'(bus.rsp_sum), 64'd3);
    end
    cycle(1'b1);
    chk("bp_refill_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_refill_id",    64'(bus.rsp_id),    64'd2);
    chk("bp_refill_sum",   64'(bus.rsp_sum),   64'd30);

    // Asynchronous reset while FULL with the pointer at 2.
    set_req(1, 32'd4, 32'd4, 1'b0);
    cycle(1'b1);
    cycle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
    reset_model();
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd100, 32'd1, 1'b0);
    set_req(3, 32'd200, 32'd2, 1'b0);
    cycle(1'b1);
    chk("post_rst_id", 64'(bus.rsp_id), 64'd0);
    cycle(1'b1);
    chk("post_rst_id3", 64'(bus.rsp_id), 64'd3);

    // Randomized traffic with random backpressure.
    mode = 2;
    repeat (400) cycle($urandom_range(0, 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
